pipeline_main_control: RTL
==========================

Name: pipeline_main_control

Overview:
- Main control unit driving the 5-stage pipelined datapath's control inputs from the ID-stage opcode.
- It is the other end of the datapath's OpCode/isZero interface: the datapath reports the opcode and zero flag, and this block returns the control bundle.
- Also tracks in-flight branches, squashes wrong-path instructions after a taken branch or jump, and implements a HALT state.
- Sits beside the datapath; the datapath's ID/EX register captures its control outputs.

Parameters:
- BR_SQUASH, 3, bubble cycles after a taken branch resolves (wrong-path instructions in IF/ID/EX).
- J_SQUASH, 1, bubble cycles after a jump is decoded.
- HALT_OPCODE, 6'h3F, opcode that stops the pipeline.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] of ID-stage instruction
- is_zero  in  1  registered ALU zero flag at MEM stage (aligned with a branch reaching MEM)
- reg_dst  out  1  write-register select (1 = rd)
- reg_write  out  1  register file write enable
- alu_op  out  2  ALU control class (00 add, 01 sub, 10 funct)
- alu_src  out  1  ALU operand 2 = sign-extended immediate
- mem_read  out  1  data memory read
- mem_write  out  1  data memory write
- mem_to_reg  out  1  write-back source = memory
- branch  out  1  beq in ID
- jump  out  1  j in ID
- branch_taken  out  1  one-cycle pulse: tracked branch resolved taken this cycle
- squash  out  1  high while control outputs are forced to bubble
- halted  out  1  high in HALT state

Behaviour:
- Decode is combinational from opcode; all other fields 0 unless listed:
  - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 0x23 lw: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - 0x2B sw: alu_src=1, mem_write=1, alu_op=00.
  - 0x04 beq: branch=1, alu_op=01.
  - 0x02 j: jump=1.
  - 0x08 addi: alu_src=1, reg_write=1, alu_op=00.
  - Any other opcode: all zero (treated as nop).
- Gating: the decoded bundle is output only in RUN. In SQUASH, HALT, or while rst=1, all control outputs are 0 and squash reflects the state.
- States:
  - RUN: normal issue.
  - SQUASH: a down-counter sq_cnt (width sized to max(BR_SQUASH, J_SQUASH)) forces bubbles.
  - HALT: terminal until reset.
- Branch tracking:
  - 2-deep shift register br_ex <= branch_out, br_mem <= br_ex, where branch_out is the gated branch output.
  - Resolution occurs when br_mem=1 and is_zero=1: branch_taken=1 that cycle, state <= SQUASH, sq_cnt <= BR_SQUASH-1, br_ex/br_mem cleared next edge.
  - br_mem=1 with is_zero=0: no action.
- Jump: jump output high in RUN. Next edge: state <= SQUASH, sq_cnt <= J_SQUASH-1 (skipped if J_SQUASH=0).
- SQUASH countdown: sq_cnt decrements each cycle. State returns to RUN on the edge where sq_cnt==0.
  - Squashed opcodes have no effect: no branch tracking, no jump, no halt.
- HALT: opcode==HALT_OPCODE in RUN → state <= HALT next edge. halted=1 and outputs stay 0 until rst.
- Priority at the same edge: taken-branch resolution > halt > jump. A HALT or jump in ID in the same cycle as a resolving taken branch is wrong-path and is dropped.
- Branch issued in the shadow of an untaken older branch is tracked normally; both can be in flight.
- Reset (any state, including mid-squash or HALT):
  - next edge: state=RUN, sq_cnt=0, br_ex=br_mem=0.
  - branch_taken=0, squash=0, halted=0.
- Latency: control outputs 0 cycles from opcode; branch_taken 0 cycles from is_zero; squash begins the cycle after the triggering event.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - Extra output port illegal_op (1 bit, sticky).
  - An unlisted opcode decoded in RUN sets illegal_op and enters HALT next edge.
  - Cleared only by rst.
- Undefined: no port; unlisted opcodes decode as nop and execution continues.

Test Plan:
- Reset then opcode=0x23 → mem_read=1, mem_to_reg=1, reg_write=1, alu_src=1, alu_op=00, squash=0.
- beq (0x04) at cycle N, filler R-types, is_zero=1 at N+2 → branch_taken pulse at N+2; squash=1 and all controls 0 at N+3..N+5; RUN and R-type controls at N+6.
- beq at N, is_zero=0 at N+2 → no branch_taken, no squash, following sw (0x2B) gives mem_write=1 at N+1.
- j (0x02) at N → jump=1 at N; squash=1 at N+1; RUN at N+2. A 0x3F presented at N+1 does not halt.
- opcode=0x3F → halted=1 next cycle, lw presented afterwards gives all-zero outputs. rst one cycle → RUN, lw decodes normally.
- Assert rst during a BR_SQUASH window (second bubble) → next cycle squash=0 and opcode 0x00 yields reg_dst=1, reg_write=1, alu_op=10. With ILLEGAL_OP_TRAP_EN, opcode 0x11 → illegal_op=1, halted=1.

Source files
------------

// File: rtl/pipeline_main_control_if.sv
// rtl/pipeline_main_control_if.sv - opcode/zero-flag in, control bundle out, between datapath and main control
// Optional ILLEGAL_OP_TRAP_EN adds the sticky illegal_op signal.
interface pipeline_main_control_if;
  logic [5:0] opcode;
  logic       is_zero;
  logic       reg_dst;
  logic       reg_write;
  logic [1:0] alu_op;
  logic       alu_src;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       branch;
  logic       jump;
  logic       branch_taken;
  logic       squash;
  logic       halted;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;

  modport master (
    output opcode, is_zero,
    input  reg_dst, reg_write, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
    input  branch, jump, branch_taken, squash, halted, illegal_op
  );
  modport slave (
    input  opcode, is_zero,
    output reg_dst, reg_write, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
    output branch, jump, branch_taken, squash, halted, illegal_op
  );
`else
  modport master (
    output opcode, is_zero,
    input  reg_dst, reg_write, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
    input  branch, jump, branch_taken, squash, halted
  );
  modport slave (
    input  opcode, is_zero,
    output reg_dst, reg_write, alu_op, alu_src, mem_read, mem_write, mem_to_reg,
    output branch, jump, branch_taken, squash, halted
  );
`endif
endinterface

// File: rtl/pipeline_main_control.sv
// rtl/pipeline_main_control.sv - ID-stage main control with branch tracking, squash and halt
// Optional ILLEGAL_OP_TRAP_EN: unlisted opcodes set sticky illegal_op and halt.
module pipeline_main_control #(
  parameter int          BR_SQUASH   = 3,
  parameter int          J_SQUASH    = 1,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_main_control_if.slave ctl
);
  localparam int SQ_MAX = (BR_SQUASH > J_SQUASH) ? BR_SQUASH : J_SQUASH;
  localparam int CNT_W  = (SQ_MAX > 2) ? $clog2(SQ_MAX) : 1;
  localparam logic [CNT_W-1:0] BR_LOAD = CNT_W'((BR_SQUASH > 0) ? BR_SQUASH - 1 : 0);
  localparam logic [CNT_W-1:0] J_LOAD  = CNT_W'((J_SQUASH > 0) ? J_SQUASH - 1 : 0);

  typedef enum logic [1:0] {RUN, SQUASH, HALT} ctlState_t;

  ctlState_t        state, stateNext;
  logic [CNT_W-1:0] sqCnt, sqCntNext;
  logic             brEx, brMem;
  logic             issue, taken, haltReq, isHaltOp;
  logic             dRegDst, dRegWrite, dAluSrc, dMemRead, dMemWrite, dMemToReg, dBranch, dJump;
  logic [1:0]       dAluOp;

  always_comb begin
    dRegDst   = 1'b0;
    dRegWrite = 1'b0;
    dAluOp    = 2'b00;
    dAluSrc   = 1'b0;
    dMemRead  = 1'b0;
    dMemWrite = 1'b0;
    dMemToReg = 1'b0;
    dBranch   = 1'b0;
    dJump     = 1'b0;
    case (ctl.opcode)
      6'h00: begin dRegDst = 1'b1; dRegWrite = 1'b1; dAluOp = 2'b10; end
      6'h23: begin dAluSrc = 1'b1; dMemToReg = 1'b1; dRegWrite = 1'b1; dMemRead = 1'b1; end
      6'h2B: begin dAluSrc = 1'b1; dMemWrite = 1'b1; end
      6'h04: begin dBranch = 1'b1; dAluOp = 2'b01; end
      6'h02: dJump = 1'b1;
      6'h08: begin dAluSrc = 1'b1; dRegWrite = 1'b1; end
      default: ;
    endcase
  end

  // Decoded bundle only escapes while issuing; everything else is a bubble.
  assign issue          = (state == RUN) && !rst;
  assign ctl.reg_dst    = issue & dRegDst;
  assign ctl.reg_write  = issue & dRegWrite;
  assign ctl.alu_op     = issue ? dAluOp : 2'b00;
  assign ctl.alu_src    = issue & dAluSrc;
  assign ctl.mem_read   = issue & dMemRead;
  assign ctl.mem_write  = issue & dMemWrite;
  assign ctl.mem_to_reg = issue & dMemToReg;
  assign ctl.branch     = issue & dBranch;
  assign ctl.jump       = issue & dJump;

  assign taken            = brMem && ctl.is_zero && (state != HALT) && !rst;
  assign ctl.branch_taken = taken;
  assign ctl.squash       = (state == SQUASH) && !rst;
  assign ctl.halted       = (state == HALT) && !rst;
  assign isHaltOp         = (ctl.opcode == HALT_OPCODE);

`ifdef ILLEGAL_OP_TRAP_EN
  logic listed, illegalOp;
  assign listed  = (ctl.opcode inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
  assign haltReq = isHaltOp || !listed;

  always_ff @(posedge clk) begin
    if (rst)
      illegalOp <= 1'b0;
    else if (issue && !taken && !listed && !isHaltOp)
      illegalOp <= 1'b1;
  end
  assign ctl.illegal_op = illegalOp;
`else
  assign haltReq = isHaltOp;
`endif

  // Taken-branch resolution outranks halt and jump: anything in ID then is wrong-path.
  always_comb begin
    stateNext = state;
    sqCntNext = sqCnt;
    case (state)
      RUN: begin
        if (taken) begin
          if (BR_SQUASH > 0) begin
            stateNext = SQUASH;
            sqCntNext = BR_LOAD;
          end
        end else if (haltReq) begin
          stateNext = HALT;
        end else if (dJump && (J_SQUASH > 0)) begin
          stateNext = SQUASH;
          sqCntNext = J_LOAD;
        end
      end
      SQUASH: begin
        if (taken && (BR_SQUASH > 0)) begin
          sqCntNext = BR_LOAD;
        end else if (sqCnt == '0) begin
          stateNext = RUN;
        end else begin
          sqCntNext = sqCnt - CNT_W'(1);
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      sqCnt <= '0;
      brEx  <= 1'b0;
      brMem <= 1'b0;
    end else begin
      state <= stateNext;
      sqCnt <= sqCntNext;
      if (taken) begin
        brEx  <= 1'b0;
        brMem <= 1'b0;
      end else begin
        brEx  <= ctl.branch;
        brMem <= brEx;
      end
    end
  end
endmodule
